// File: rtl/multi_key_decoder.sv
// multi_key_decoder
// Tracks NUM_KEYS PS/2 keys in parallel from the shared scan-code stream.
// For each key it provides a level, one-cycle rise/fall pulses, a toggle latch
// and an optional typematic auto-repeat pulse.
// Build option: define KEY_REPEAT_EN to compile in the per-key repeat counters
// and FSMs. Without it keyRepeatPulse is tied low and REPEAT_DELAY and
// REPEAT_PERIOD have no effect.
// Channel i matches KEY_CODES[9*i+8:9*i], so the last code in a concatenation
// literal belongs to channel 0.
module multi_key_decoder #(
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h029, 9'h16B, 9'h174, 9'h076},
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [8:0]          keyCode,
  input  logic                make,
  input  logic                brakee,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0] keyFallingEdgePulse,
  output logic [NUM_KEYS-1:0] keyLatch,
  output logic [NUM_KEYS-1:0] keyRepeatPulse,
  output logic                anyKeyPressed
);

  logic [NUM_KEYS-1:0] pressed_q;
  logic [NUM_KEYS-1:0] pressed_d;
  logic [NUM_KEYS-1:0] pressed_dly_q;
  logic [NUM_KEYS-1:0] latch_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  genvar gi;

  // Next level per channel. A release beats a press in the same cycle, and a
  // make on a held key just keeps it held (typematic resend is a no-op).
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_level
      logic code_hit;
      assign code_hit      = (keyCode == KEY_CODES[gi*9 +: 9]);
      assign pressed_d[gi] = (code_hit && brakee) ? 1'b0 :
                             (code_hit && make)   ? 1'b1 : pressed_q[gi];
    end
  endgenerate

  assign rise = pressed_q & ~pressed_dly_q;
  assign fall = ~pressed_q & pressed_dly_q;

  // Level, one-cycle-delayed level and toggle latch for every channel
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pressed_q     <= '0;
      pressed_dly_q <= '0;
      latch_q       <= '0;
    end else begin
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
      latch_q       <= latch_q ^ rise;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // The FSM looks at the next level so that a press sampled at edge N starts
  // counting at once (first pulse visible in cycle N+REPEAT_DELAY+1) and a
  // release sampled at edge M suppresses any pulse from edge M onward.
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_repeat
      rpt_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pulse_q, pulse_d;

      // Repeat state, counter and registered pulse
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          state_q <= RPT_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          pulse_q <= pulse_d;
        end
      end

      // Next state: wait REPEAT_DELAY, then pulse every REPEAT_PERIOD while held
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!pressed_d[gi]) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              state_d = RPT_DELAY;
              cnt_d   = '0;
            end
            RPT_DELAY: begin
              if (cnt_q == DELAY_LAST) begin
                pulse_d = 1'b1;
                state_d = RPT_REPEAT;
                cnt_d   = '0;
              end else if (cnt_q != CNT_TOP) begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            RPT_REPEAT: begin
              if (cnt_q == PERIOD_LAST) begin
                pulse_d = 1'b1;
                cnt_d   = '0;
              end else if (cnt_q != CNT_TOP) begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: begin
              state_d = RPT_IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      assign keyRepeatPulse[gi] = pulse_q;
    end
  endgenerate
`else
  assign keyRepeatPulse = '0;
`endif

  assign keyIsPressed        = pressed_q;
  assign keyRisingEdgePulse  = rise;
  assign keyFallingEdgePulse = fall;
  assign keyLatch            = latch_q;
  assign anyKeyPressed       = |pressed_q;

endmodule

// File: tb/tb_multi_key_decoder.sv
// Self-checking bench for multi_key_decoder: a per-cycle scoreboard fed by a
// behavioural key model (press times, parity of presses, repeat arithmetic).
module tb_multi_key_decoder;

  localparam int NK = 4;
  localparam int RD = 10;
  localparam int RP = 4;
  localparam logic [8:0] CODE_TAB [NK] = '{9'h029, 9'h16B, 9'h174, 9'h076};

  logic          clk = 1'b0;
  logic          resetN;
  logic [8:0]    keyCode;
  logic          make;
  logic          brakee;
  logic [NK-1:0] keyIsPressed;
  logic [NK-1:0] keyRisingEdgePulse;
  logic [NK-1:0] keyFallingEdgePulse;
  logic [NK-1:0] keyLatch;
  logic [NK-1:0] keyRepeatPulse;
  logic          anyKeyPressed;

  always #5 clk = ~clk;

  multi_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ({9'h076, 9'h174, 9'h16B, 9'h029}),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .keyCode             (keyCode),
    .make                (make),
    .brakee              (brakee),
    .keyIsPressed        (keyIsPressed),
    .keyRisingEdgePulse  (keyRisingEdgePulse),
    .keyFallingEdgePulse (keyFallingEdgePulse),
    .keyLatch            (keyLatch),
    .keyRepeatPulse      (keyRepeatPulse),
    .anyKeyPressed       (anyKeyPressed)
  );

  typedef struct {
    int            tag;
    logic [NK-1:0] pr;
    logic [NK-1:0] ri;
    logic [NK-1:0] fa;
    logic [NK-1:0] la;
    logic [NK-1:0] rp;
    logic          an;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt  = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   rep2_seen = 0;

  // model state: level after last edge, level one edge earlier, latch, press edge
  bit m_pr   [NK];
  bit m_prev [NK];
  bit m_la   [NK];
  int m_pedge[NK];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NK; i++) begin
      m_pr[i] = 1'b0; m_prev[i] = 1'b0; m_la[i] = 1'b0; m_pedge[i] = 0;
    end
  endtask

  // Expected outputs after edge t given the inputs sampled at that edge
  task automatic model_step(input int t, input logic [8:0] kc, input bit mk, input bit br,
                            output exp_t e);
    e.tag = t; e.pr = '0; e.ri = '0; e.fa = '0; e.la = '0; e.rp = '0;
    for (int i = 0; i < NK; i++) begin
      if (!resetN) begin
        m_pr[i] = 1'b0; m_prev[i] = 1'b0; m_la[i] = 1'b0;
      end else begin
        if (m_pr[i] && !m_prev[i]) m_la[i] = !m_la[i];
        m_prev[i] = m_pr[i];
        if (kc == CODE_TAB[i]) begin
          if (br) m_pr[i] = 1'b0;
          else if (mk && !m_pr[i]) begin
            m_pr[i]    = 1'b1;
            m_pedge[i] = t;
          end
        end
      end
      e.pr[i] = m_pr[i];
      e.ri[i] = m_pr[i] && !m_prev[i];
      e.fa[i] = !m_pr[i] && m_prev[i];
      e.la[i] = m_la[i];
`ifdef KEY_REPEAT_EN
      if (m_pr[i] && (t - m_pedge[i]) >= RD && ((t - m_pedge[i] - RD) % RP) == 0)
        e.rp[i] = 1'b1;
`endif
    end
    e.an = |e.pr;
  endtask

  task automatic step(input logic [8:0] kc, input bit mk, input bit br);
    exp_t e;
    @(negedge clk); #1;
    keyCode = kc; make = mk; brakee = br;
    model_step(edge_cnt + 1, kc, mk, br, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(9'($urandom), 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pressed"}, 32'(keyIsPressed), 32'd0);
    chk({tag, "_rise"},    32'(keyRisingEdgePulse), 32'd0);
    chk({tag, "_fall"},    32'(keyFallingEdgePulse), 32'd0);
    chk({tag, "_latch"},   32'(keyLatch), 32'd0);
    chk({tag, "_repeat"},  32'(keyRepeatPulse), 32'd0);
    chk({tag, "_any"},     32'(anyKeyPressed), 32'd0);
  endtask

  task automatic set_reset(input bit v);
    exp_t e;
    @(negedge clk); #1;
    resetN = v; make = 1'b0; brakee = 1'b0;
    if (!v) begin
      model_clear();
      #1 check_all_zero("async_rst");
    end
    model_step(edge_cnt + 1, keyCode, 1'b0, 1'b0, e);
    sb_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs with the scoreboard entry for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (keyRepeatPulse[2]) rep2_seen++;
      while (sb_q.size() > 0 && sb_q[0].tag < edge_cnt) begin
        e = sb_q.pop_front();
        chk("sb_stale_entry", 32'(e.tag), 32'(edge_cnt));
      end
      if (sb_q.size() > 0 && sb_q[0].tag == edge_cnt) begin
        e = sb_q.pop_front();
        chk("pressed", 32'(keyIsPressed),        32'(e.pr));
        chk("rise",    32'(keyRisingEdgePulse),  32'(e.ri));
        chk("fall",    32'(keyFallingEdgePulse), 32'(e.fa));
        chk("latch",   32'(keyLatch),            32'(e.la));
        chk("repeat",  32'(keyRepeatPulse),      32'(e.rp));
        chk("any",     32'(anyKeyPressed),       32'(e.an));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_rep;
    int r;
    logic [8:0] kc;
    bit mk, br;

    resetN = 1'b0; keyCode = '0; make = 1'b0; brakee = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_state");
    set_reset(1'b1);
    idle(4);

    // press / release on channel 0
    step(9'h029, 1'b1, 1'b0);
    idle(14);
    step(9'h029, 1'b0, 1'b1);
    idle(3);

    // latch toggle on channel 1: expect 1, 0, 1
    for (int k = 0; k < 3; k++) begin
      step(9'h16B, 1'b1, 1'b0);
      idle(2);
      step(9'h16B, 1'b0, 1'b1);
      idle(2);
      chk("latch1_sequence", 32'(keyLatch[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // auto-repeat on channel 2: held for 30 cycles
    base = rep2_seen;
    step(9'h174, 1'b1, 1'b0);
    idle(29);
    step(9'h174, 1'b0, 1'b1);
    idle(6);
`ifdef KEY_REPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 0;
`endif
    chk("repeat2_pulse_count", 32'(rep2_seen - base), 32'(exp_rep));

    // concurrency and conflicts
    step(9'h029, 1'b1, 1'b0);
    idle(1);
    step(9'h076, 1'b1, 1'b0);
    idle(2);
    chk("any_two_held", 32'(anyKeyPressed), 32'd1);
    step(9'h076, 1'b1, 1'b1);
    idle(1);
    chk("ch3_make_brakee_low", 32'(keyIsPressed[3]), 32'd0);
    step(9'h029, 1'b1, 1'b0);
    idle(20);

    // reset while channel 0 is repeating
    set_reset(1'b0);
    idle(3);
    set_reset(1'b1);
    idle(6);

    // unmatched code
    step(9'h01C, 1'b1, 1'b0);
    idle(2);
    step(9'h01C, 1'b0, 1'b1);
    idle(2);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 4));
      kc = (r < NK) ? CODE_TAB[r] : 9'($urandom);
      mk = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 9) == 0);
      step(kc, mk, br);
    end
    idle(4);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
